chacha20_poly1305_mac_formatter: RTL
====================================

Name: chacha20_poly1305_mac_formatter

Overview:
- Upstream feeder for the ChaCha20-Poly1305 AEAD core's Poly1305 MAC path.
- Accepts the AAD byte stream, then the ciphertext byte stream, as 128-bit words.
- Zero-pads each segment to a 16-byte boundary, counts the bytes in each segment, and appends the final length block le64(aad_len) || le64(ct_len).
- Emits a stream of full 16-byte blocks with a valid/ready handshake, so the MAC never sees a partial block.

Parameters:
- LEN_W, 64: width of the AAD and ciphertext byte counters; zero-extended to 64 bits in the length block.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new message; honoured only when ready=1
- ready  out  1  high in IDLE
- in_valid  in  1  input word valid
- in_ready  out  1  formatter accepts the input word this cycle
- in_data  in  128  input bytes; byte 0 is at [127:120]
- in_bytes  in  5  number of valid bytes in the word, 0..16
- in_last  in  1  last word of the current segment (AAD or CT)
- blk_valid  out  1  output block valid
- blk_ready  in  1  downstream accepts the block
- blk_data  out  128  padded block; byte 0 is at [127:120]
- blk_final  out  1  marks the current block as the length block
- done  out  1  one-cycle pulse after the length block is accepted
- error  out  1  sticky format-error flag; cleared by start

Behaviour:
- Reset values:
  - state=IDLE
  - ready=1
  - in_ready=0, blk_valid=0, blk_final=0, blk_data=0
  - done=0, error=0
  - both byte counters=0
- A reset asserted mid-message aborts it immediately: the output register is discarded and no done pulse is produced.
- FSM states: IDLE, AAD, CT, LEN, FIN.
  - IDLE, start=1 -> AAD. Clears counters and error. start is ignored in any other state.
  - AAD, accepted word with in_last=1 -> CT.
  - CT, accepted word with in_last=1 -> LEN.
  - LEN, length block loaded into the output register -> FIN.
  - FIN, length block accepted (blk_valid & blk_ready) -> IDLE, with done=1 in that same cycle.
- Single output register, one-cycle latency:
  - in_ready = (state is AAD or CT) & (!blk_valid | blk_ready).
  - A word is accepted when in_valid & in_ready.
  - On acceptance with in_bytes>0, the register loads in_data with bytes at index >= in_bytes forced to 0, and blk_valid=1 on the next cycle.
  - in_bytes=0 with in_last=1 is an empty-segment terminator: the state advances, no block is emitted, and the counter is unchanged.
  - blk_valid clears after acceptance unless a new block loads in the same cycle. Back-to-back throughput is one block per cycle.
- Counters:
  - The segment counter (aad_len in AAD, ct_len in CT) adds in_bytes, clamped to 16, on each accepted word.
  - Addition wraps modulo 2^LEN_W.
- Length block:
  - Loaded in LEN when the output register is free (!blk_valid | blk_ready).
  - blk_data = {byteswap64(aad_len), byteswap64(ct_len)}, i.e. aad_len little-endian in bytes 0..7 and ct_len little-endian in bytes 8..15.
  - blk_final=1 for this block only.
- error is set, and processing continues, on any of:
  - in_bytes>16 (treated as 16);
  - in_bytes<16 on a word with in_last=0 (padded as given; the byte count uses the given value);
  - in_bytes=0 with in_last=0 (word dropped, no block emitted).
- Backpressure: blk_valid, blk_data and blk_final are held stable while blk_valid & !blk_ready.
- in_valid is ignored in IDLE, LEN and FIN.

Decomposition:
- Shared package chacha20_poly1305_pkg holds:
  - the FSM state encodings;
  - BLOCK_BYTES=16;
  - a byteswap64 function;
  - a byte-mask function mapping in_bytes to a 128-bit mask.
- Sub-module chacha20_poly1305_pad_mask: combinational zero-padding of in_data by in_bytes. The rest is a single module.

Test Plan:
- RFC 8439 §2.8.2 vector, 12-byte AAD then 114-byte CT:
  - 1 AAD block: bytes 12..15 zero;
  - 8 CT blocks: the 8th has only bytes 0..1 non-zero;
  - length block 128'h0c000000_00000000_72000000_00000000 with blk_final=1;
  - done one cycle after its acceptance.
- Empty AAD (in_bytes=0, in_last=1), then one 16-byte CT word: exactly 2 blocks; length block 128'h00000000_00000000_10000000_00000000.
- blk_ready held low 5 cycles during CT:
  - in_ready=0 while the register is full;
  - blk_data stable throughout;
  - no words lost or duplicated;
  - full rate resumes once blk_ready returns.
- Non-last word with in_bytes=5: error=1, the block is padded after byte 4, and the final length reflects 5. A subsequent start clears error.
- reset asserted while in CT with blk_valid=1: next cycle blk_valid=0, ready=1, no done; a new message then completes correctly.
- start pulsed during AAD: ignored, counters and state unaffected.

Source files
------------

// File: rtl/chacha20_poly1305_pkg.sv
// Shared definitions for the Poly1305 MAC input formatter: FSM states,
// block geometry and the byte helpers used for padding and the length block.
package chacha20_poly1305_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    AAD,
    CT,
    LEN,
    FIN
  } fmt_state_e;

  function automatic logic [63:0] byteswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = x[56-8*i +: 8];
    end
    return r;
  endfunction

  // Ones over the leading n bytes (byte 0 is the MSB); n above 16 saturates.
  function automatic logic [127:0] byteMask(input logic [4:0] n);
    logic [4:0] clamped;
    logic [7:0] shift;
    clamped = (n > 5'(BLOCK_BYTES)) ? 5'(BLOCK_BYTES) : n;
    shift   = {clamped, 3'b000};
    return ~({128{1'b1}} >> shift);
  endfunction

endpackage

// File: rtl/chacha20_poly1305_pad_mask.sv
// Combinational zero-padding: keeps the first bytes_i bytes of data_i and
// clears the rest.
module chacha20_poly1305_pad_mask
  import chacha20_poly1305_pkg::*;
(
  input  logic [127:0] data_i,
  input  logic [4:0]   bytes_i,
  output logic [127:0] data_o
);

  assign data_o = data_i & byteMask(bytes_i);

endmodule

// File: rtl/chacha20_poly1305_mac_formatter.sv
// Formats AAD and ciphertext into padded 16-byte Poly1305 blocks and appends
// the le64(aad_len) || le64(ct_len) length block.
module chacha20_poly1305_mac_formatter
  import chacha20_poly1305_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic         blk_final,
  output logic         done,
  output logic         error
);

  fmt_state_e       state_q, state_d;
  logic [LEN_W-1:0] aadLen_q, aadLen_d;
  logic [LEN_W-1:0] ctLen_q, ctLen_d;
  logic [127:0]     blkData_q, blkData_d;
  logic             blkValid_q, blkValid_d;
  logic             blkFinal_q, blkFinal_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [4:0]   effBytes;
  logic [127:0] paddedData;
  logic         regFree;
  logic         accept;
  logic         fmtErr;

  assign effBytes = (in_bytes > 5'(BLOCK_BYTES)) ? 5'(BLOCK_BYTES) : in_bytes;
  assign fmtErr   = (in_bytes > 5'(BLOCK_BYTES)) ||
                    ((in_bytes < 5'(BLOCK_BYTES)) && !in_last);
  assign regFree  = !blkValid_q || blk_ready;
  assign in_ready = ((state_q == AAD) || (state_q == CT)) && regFree;
  assign accept   = in_valid && in_ready;

  chacha20_poly1305_pad_mask u_pad (
    .data_i  (in_data),
    .bytes_i (effBytes),
    .data_o  (paddedData)
  );

  always_comb begin
    state_d    = state_q;
    aadLen_d   = aadLen_q;
    ctLen_d    = ctLen_q;
    blkData_d  = blkData_q;
    blkValid_d = blkValid_q;
    blkFinal_d = blkFinal_q;
    done_d     = 1'b0;
    error_d    = error_q;

    // A consumed block frees the register; a load below may refill it.
    if (blkValid_q && blk_ready) begin
      blkValid_d = 1'b0;
      blkFinal_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = AAD;
          aadLen_d = '0;
          ctLen_d  = '0;
          error_d  = 1'b0;
        end
      end
      AAD, CT: begin
        if (accept) begin
          if (fmtErr) error_d = 1'b1;
          if (effBytes != 5'd0) begin
            blkData_d  = paddedData;
            blkValid_d = 1'b1;
            blkFinal_d = 1'b0;
          end
          if (state_q == AAD) aadLen_d = aadLen_q + LEN_W'(effBytes);
          else                ctLen_d  = ctLen_q + LEN_W'(effBytes);
          if (in_last) state_d = (state_q == AAD) ? CT : LEN;
        end
      end
      LEN: begin
        if (regFree) begin
          blkData_d  = {byteswap64(64'(aadLen_q)), byteswap64(64'(ctLen_q))};
          blkValid_d = 1'b1;
          blkFinal_d = 1'b1;
          state_d    = FIN;
        end
      end
      FIN: begin
        if (blkValid_q && blk_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      aadLen_q   <= '0;
      ctLen_q    <= '0;
      blkData_q  <= '0;
      blkValid_q <= 1'b0;
      blkFinal_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      aadLen_q   <= aadLen_d;
      ctLen_q    <= ctLen_d;
      blkData_q  <= blkData_d;
      blkValid_q <= blkValid_d;
      blkFinal_q <= blkFinal_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign blk_valid = blkValid_q;
  assign blk_data  = blkData_q;
  assign blk_final = blkFinal_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
